// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the ccff chain loader.
// Imported by the loader top and its word serializer.
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int CHAIN_LEN_DEF = 16;
  localparam int WORD_W_DEF    = 8;
  localparam int BL_W_DEF      = clog2(CHAIN_LEN_DEF + 1);

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer for the ccff loader: parallel load, LSB-first
// shift-out, and a count of bits still held in the buffer.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int HC_W   = clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word_in,
  input  logic [HC_W-1:0]   load_cnt,
  output logic              lsb,
  output logic [HC_W-1:0]   hold_cnt
);

  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [HC_W-1:0]   cnt_q, cnt_d;

  // A load on a shift edge replaces the buffer; the old
  // bit 0 still leaves on that same edge.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (clear) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (load) begin
      sreg_d = word_in;
      cnt_d  = load_cnt;
    end else if (shift) begin
      sreg_d = {1'b0, sreg_q[WORD_W-1:1]};
      cnt_d  = cnt_q - HC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lsb      = sreg_q[0];
  assign hold_cnt = cnt_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words onto a tile's ccff chain and
// folds the bits leaving the chain tail into a parity.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic                             prog_clk,
  input  logic                             prog_reset,
  input  logic                             start,
  input  logic [WORD_W-1:0]                word_in,
  input  logic                             word_valid,
  output logic                             word_ready,
  output logic                             ccff_head,
  output logic                             ccff_shift_en,
  input  logic                             ccff_tail,
  output logic                             busy,
  output logic                             done,
  output logic                             tail_parity,
  output logic [clog2(CHAIN_LEN+1)-1:0]    bits_left
);

  localparam int BL_W = clog2(CHAIN_LEN + 1);
  localparam int HC_W = clog2(WORD_W + 1);
  localparam int CW   = (BL_W > HC_W) ? BL_W : HC_W;

  localparam logic [CW-1:0]   WORD_CW = CW'(WORD_W);
  localparam logic [BL_W-1:0] LEN_BL  = BL_W'(CHAIN_LEN);

  state_e          state_q, state_d;
  logic [BL_W-1:0] left_q, left_d;
  logic            par_q, par_d;
  logic            tpar_q, tpar_d;

  logic            in_load;
  logic            clear;
  logic            accept;
  logic            head_bit;
  logic [HC_W-1:0] hold_cnt;
  logic [HC_W-1:0] load_cnt;
  logic [CW-1:0]   hold_cw;
  logic [CW-1:0]   left_cw;
  logic [CW-1:0]   rem_cw;

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .HC_W   (HC_W)
  ) u_ser (
    .clk      (prog_clk),
    .rst      (prog_reset),
    .clear    (clear),
    .load     (accept),
    .shift    (ccff_shift_en),
    .word_in  (word_in),
    .load_cnt (load_cnt),
    .lsb      (head_bit),
    .hold_cnt (hold_cnt)
  );

  // Refill only as the buffer drains, never past the chain end.
  always_comb begin
    in_load       = (state_q == ST_LOAD);
    hold_cw       = CW'(hold_cnt);
    left_cw       = CW'(left_q);
    ccff_shift_en = in_load && (hold_cnt != '0);
    ccff_head     = ccff_shift_en && head_bit;
    word_ready    = in_load
                 && (hold_cw <= CW'(1))
                 && (left_cw > hold_cw);
    accept        = word_ready && word_valid;
    rem_cw        = left_cw - CW'(ccff_shift_en);
    load_cnt      = (rem_cw > WORD_CW) ? HC_W'(WORD_W)
                                       : HC_W'(rem_cw);
  end

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    par_d   = par_q;
    tpar_d  = tpar_q;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          left_d  = LEN_BL;
          par_d   = 1'b0;
          clear   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (ccff_shift_en) begin
          left_d = left_q - BL_W'(1);
          par_d  = par_q ^ ccff_tail;
          if (left_q == BL_W'(1)) begin
            state_d = ST_DONE;
            tpar_d  = par_q ^ ccff_tail;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
      par_q   <= 1'b0;
      tpar_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      par_q   <= par_d;
      tpar_q  <= tpar_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign tail_parity = tpar_q;
  assign bits_left   = left_q;

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Bitstream loader that drives the configuration-chain (ccff) shift path of a routing tile: connection blocks, switch blocks and grid memories. It accepts parallel configuration words over a valid/ready handshake and serialises them LSB-first onto `ccff_head`, one bit per enabled `prog_clk` edge. It also asserts the chain shift-enable and folds the bits leaving `ccff_tail` into a parity of the previous configuration. It sits between the configuration controller and the head of a tile's ccff chain.

## Interface
- `CHAIN_LEN`, default 16: number of ccff flops in the driven chain (4 muxes × 4 SRAM bits); must be ≥ 1.
- `WORD_W`, default 8: width of the configuration word bus; must be ≥ 2.
- `prog_clk` in 1: the only clock.
- `prog_reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a load; sampled in IDLE only.
- `word_in` in WORD_W: configuration word; bit 0 shifts first.
- `word_valid` in 1: `word_in` is valid.
- `word_ready` out 1: loader accepts `word_in` this cycle.
- `ccff_head` out 1: serial data to the chain head.
- `ccff_shift_en` out 1: chain clock-enable; the chain shifts on a `prog_clk` edge only while this is high.
- `ccff_tail` in 1: serial data returning from the chain tail.
- `busy` out 1: high in LOAD and DONE.
- `done` out 1: one-cycle pulse when the load completes.
- `tail_parity` out 1: XOR of the CHAIN_LEN bits shifted out of `ccff_tail`; valid from `done` until the next `start`.
- `bits_left` out clog2(CHAIN_LEN+1): chain bits still to shift.

## Operation
- The FSM has three states: IDLE, LOAD and DONE.
- IDLE:
  - `start` → LOAD; set `bits_left`=CHAIN_LEN, clear parity accumulator, clear word buffer.
  - `word_ready`=0 and `ccff_shift_en`=0.
- LOAD: the word buffer holds the shift register and `hold_cnt`, the number of unshifted bits in the buffer.
  - `ccff_head` = buffer bit 0.
  - `ccff_shift_en` = (`hold_cnt` ≠ 0).
  - When `ccff_shift_en`=1, at the edge:
    - the buffer shifts right by one;
    - `hold_cnt`−1;
    - `bits_left`−1;
    - parity ^= `ccff_tail`.
  - `word_ready` = (`hold_cnt` ≤ 1) && (`bits_left` > `hold_cnt`). This gives zero-bubble back-to-back acceptance.
  - On valid&&ready:
    - the buffer loads `word_in`;
    - `hold_cnt` = min(WORD_W, `bits_left` − shifted-this-cycle).
    - Word bits beyond the remaining chain length are discarded.
  - Transition when the edge that shifts the last bit arrives (`bits_left` 1→0): go to DONE.
- DONE:
  - `done`=1 for one cycle and `tail_parity` updates from the accumulator.
  - Next state is IDLE.
- `start` outside IDLE is ignored.
- `word_valid` outside LOAD is ignored (`word_ready`=0).
- Stall: when `word_valid` is low and the buffer is empty, `ccff_shift_en`=0, so the chain holds and `ccff_head` is don't-care.

## Timing
- Reset: a synchronous `prog_reset` sets state IDLE and zeroes every output: `word_ready`, `ccff_head`, `ccff_shift_en`, `busy`, `done`, `tail_parity`, `bits_left`.
  - Reset mid-load aborts immediately.
  - The chain contents are then undefined. The controller restarts the full load.
- `ccff_head` and `ccff_shift_en` are combinational from registered state only. There is no input-to-output combinational path except `word_ready`, which has none on `word_valid`.
- The first shift occurs on the edge after the first word is accepted.
- With continuous `word_valid`, `ccff_shift_en` is high for exactly CHAIN_LEN consecutive cycles.
- `done` asserts on the cycle after the last shift edge.
- Minimum load latency, `start` to `done`, is CHAIN_LEN+2 cycles.
- Simultaneous events:
  - Last-bit shift and acceptance of a new word are mutually exclusive by the `word_ready` rule.
  - `start` and `prog_reset` together: reset wins.

## Structure
- Shared package `ccff_pkg` holds the state enum (IDLE/LOAD/DONE) and the helper function `clog2`-based width constant for `bits_left`.
- One natural sub-module, `ccff_word_serializer`, contains the buffer, `hold_cnt`, load and shift. The FSM, counter and parity stay in the top module.

## Test plan
All scenarios use a behavioural model of a 16-flop chain (CHAIN_LEN=16, WORD_W=8) clocked by `prog_clk` and gated by `ccff_shift_en`.
- **Basic load:** `start`, then words 0xA5 and 0x3C held valid → after 16 shifts, chain flop[i] (flop 0 nearest the tail) holds {0x3C,0xA5} order per LSB-first; `done` pulses at `start`+18; `bits_left`=0.
- **Back-to-back:** continuous `word_valid` → `ccff_shift_en` high exactly 16 consecutive cycles; `word_ready` high for one cycle at each word boundary.
- **Gaps:** `word_valid` dropped for 5 cycles mid-load → `ccff_shift_en` low for those cycles; final chain contents identical to the basic-load case.
- **Parity:** chain preloaded with 0x0001, then load 0x0000 ×2 → `tail_parity`=1. Preload 0x0003 → `tail_parity`=0.
- **Partial last word:** CHAIN_LEN=12, words 0xFF and 0x0F → exactly 12 shifts; the upper 4 bits of the second word are never presented; `word_ready` never asserts a third time.
- **Reset and ignored start:** `prog_reset` after 7 shifts → all outputs 0 next cycle and state IDLE. `start` while `busy` → no effect on `bits_left` or state.
